vga_timing_gen: RTL and testbench

//   Source side of the pixel-scan interface consumed by color_mapper: generates

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-scan timing source for color_mapper and the VGA DAC. Divides the
//   system clock down to the pixel rate, walks the raster position (DrawX,
//   DrawY) across the full line/frame including porches and sync, and decodes
//   sync and active-video flags straight from the raster counters so they
//   line up with DrawX/DrawY in the same cycle.
//
// Ports
//   Clk          in   system clock, all state on the rising edge
//   Reset_n      in   asynchronous active-low reset
//   VGA_Clk      out  pixel clock (low for the first half of each divide period)
//   pix_en       out  one-Clk strobe on the last Clk of each pixel
//   DrawX        out  horizontal count, 0..H_TOTAL-1
//   DrawY        out  vertical count, 0..V_TOTAL-1
//   hs           out  horizontal sync, active low
//   vs           out  vertical sync, active low
//   blank        out  1 = active display region, 0 = blanking
//   sync         out  composite sync to the DAC, tied low
//   frame_clk    out  copy of vs; game logic steps on its rising edge
//   frame_start  out  one-Clk pulse on the edge where the raster wraps to (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       VGA_Clk,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_clk,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  // All decode thresholds are pre-sized to the 10-bit counters; every bound
  // is at most H_TOTAL / V_TOTAL, so nothing wraps inside 10 bits.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [9:0]    hc;
  logic [9:0]    vc;
  // run keeps blank low until the first edge after reset release, so the
  // DAC never sees active video while the generator is still held.
  logic          run;
  logic          h_last;
  logic          v_last;

  assign pix_en = (div_cnt == DIV_LAST);
  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  // NOTE: every register below is written with non-blocking assignments so
  // that all of them update from the same pre-edge values; a blocking write
  // to hc would let the vc/frame_start logic see the already-wrapped count.
  // NOTE: the reset branch clears every state bit, which is what makes a
  // mid-frame reset restart the scan at (0,0) with no pending frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt     <= '0;
      hc          <= '0;
      vc          <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      div_cnt     <= pix_en ? '0 : div_cnt + DW'(1);
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        if (h_last) begin
          hc <= '0;
          vc <= v_last ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  // Decode is purely combinational from the counters: zero skew to DrawX/Y.
  assign VGA_Clk   = (div_cnt >= DIV_HALF);
  assign DrawX     = hc;
  assign DrawY     = vc;
  assign hs        = !((hc >= HS_START) && (hc < HS_END));
  assign vs        = !((vc >= VS_START) && (vc < VS_END));
  assign blank     = run && (hc < H_VIS) && (vc < V_VIS);
  assign sync      = 1'b0;
  assign frame_clk = vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Small raster for multi-frame tests: 35 x 21 pixels, 1470 Clk per frame.
  localparam int S_HV = 20, S_HF = 4, S_HS = 6, S_HB = 5;
  localparam int S_VV = 12, S_VF = 3, S_VS = 2, S_VB = 4;
  localparam int S_FRAME = 2 * (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic rst_def, rst_small, rst_d4;

  logic       d_vga, d_pix, d_hs, d_vs, d_blank, d_sync, d_fclk, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_vga, s_pix, s_hs, s_vs, s_blank, s_sync, s_fclk, s_fs;
  logic [9:0] s_x, s_y;
  logic       q_vga, q_pix, q_hs, q_vs, q_blank, q_sync, q_fclk, q_fs;
  logic [9:0] q_x, q_y;

  vga_timing_gen u_def (
    .Clk(Clk), .Reset_n(rst_def), .VGA_Clk(d_vga), .pix_en(d_pix),
    .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .sync(d_sync), .frame_clk(d_fclk), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_small (
    .Clk(Clk), .Reset_n(rst_small), .VGA_Clk(s_vga), .pix_en(s_pix),
    .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .sync(s_sync), .frame_clk(s_fclk), .frame_start(s_fs)
  );

  vga_timing_gen #(.CLK_DIV(4)) u_d4 (
    .Clk(Clk), .Reset_n(rst_d4), .VGA_Clk(q_vga), .pix_en(q_pix),
    .DrawX(q_x), .DrawY(q_y), .hs(q_hs), .vs(q_vs), .blank(q_blank),
    .sync(q_sync), .frame_clk(q_fclk), .frame_start(q_fs)
  );

  logic [27:0] obs_d, obs_s, obs_q;
  assign obs_d = {d_vga, d_pix, d_x, d_y, d_hs, d_vs, d_blank, d_sync, d_fclk, d_fs};
  assign obs_s = {s_vga, s_pix, s_x, s_y, s_hs, s_vs, s_blank, s_sync, s_fclk, s_fs};
  assign obs_q = {q_vga, q_pix, q_x, q_y, q_hs, q_vs, q_blank, q_sync, q_fclk, q_fs};

  int n_cmp = 0;
  int n_bad = 0;
  // Rising Clk edges seen with reset released, per instance.
  int t_def = 0, t_small = 0, t_d4 = 0;

  // Reference model: the whole output vector follows from the number of Clk
  // edges since reset release, using plain division and range tests.
  function automatic logic [27:0] model(input bit in_rst, input int t, input int d,
                                        input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, p, x, y;
    logic vga, pe, h, v, bl, fs;
    if (in_rst) return {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    p   = t / d;
    x   = p % ht;
    y   = (p / ht) % vt;
    vga = (t % d) >= (d / 2);
    pe  = (t % d) == (d - 1);
    h   = !(x >= hv + hf && x < hv + hf + hsw);
    v   = !(y >= vv + vf && y < vv + vf + vsw);
    bl  = (t >= 1) && (x < hv) && (y < vv);
    fs  = (t > 0) && ((t % (d * ht * vt)) == 0);
    return {vga, pe, 10'(x), 10'(y), h, v, bl, 1'b0, v, fs};
  endfunction

  function automatic logic [27:0] exp_d();
    return model(!rst_def, t_def, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic logic [27:0] exp_s();
    return model(!rst_small, t_small, 2, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
  endfunction
  function automatic logic [27:0] exp_q();
    return model(!rst_d4, t_d4, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  // Advance one Clk for every instance; sample 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    if (rst_def)   t_def++;
    if (rst_small) t_small++;
    if (rst_d4)    t_d4++;
    #1;
  endtask

  task automatic test_reset();
    int hold;
    hold = 5 + int'($urandom_range(0, 3));
    for (int i = 0; i < hold; i++) begin
      step();
      n_cmp++;
      if (obs_d !== exp_d()) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs_d, exp_d());
      end
    end
    rst_def = 1'b1;
    #1;
    n_cmp++;
    if (obs_d !== exp_d()) begin
      n_bad++;
      $display("FAIL reset_release got=%h exp=%h", obs_d, exp_d());
    end
    step();
    n_cmp++;
    if (d_blank !== 1'b1) begin
      n_bad++;
      $display("FAIL first_edge_blank got=%b exp=1", d_blank);
    end
    step();
    n_cmp++;
    if (d_x !== 10'd1) begin
      n_bad++;
      $display("FAIL drawx_after_2clk got=%0d exp=1", d_x);
    end
  endtask

  task automatic test_line();
    logic prev_hs;
    logic [9:0] prev_x, prev_y;
    int falls, rises, wraps;
    falls = 0; rises = 0; wraps = 0;
    prev_hs = d_hs; prev_x = d_x; prev_y = d_y;
    for (int i = 0; i < 1700; i++) begin
      step();
      n_cmp++;
      if (obs_d !== exp_d()) begin
        n_bad++;
        if (n_bad < 40) $display("FAIL line_vec t=%0d got=%h exp=%h", t_def, obs_d, exp_d());
      end
      if (prev_hs && !d_hs) begin
        falls++;
        n_cmp++;
        if (d_x !== 10'd656) begin
          n_bad++;
          $display("FAIL hs_fall_x got=%0d exp=656", d_x);
        end
      end
      if (!prev_hs && d_hs) begin
        rises++;
        n_cmp++;
        if (d_x !== 10'd752) begin
          n_bad++;
          $display("FAIL hs_rise_x got=%0d exp=752", d_x);
        end
      end
      if (prev_x == 10'd799 && d_x == 10'd0) begin
        wraps++;
        n_cmp++;
        if (d_y !== prev_y + 10'd1) begin
          n_bad++;
          $display("FAIL line_wrap_y got=%0d exp=%0d", d_y, prev_y + 10'd1);
        end
      end
      prev_hs = d_hs; prev_x = d_x; prev_y = d_y;
    end
    n_cmp++;
    if (falls != 1 || rises != 1 || wraps != 1) begin
      n_bad++;
      $display("FAIL line_events got=%0d/%0d/%0d exp=1/1/1", falls, rises, wraps);
    end
  endtask

  task automatic test_midframe_reset();
    int hold;
    // Walk the default raster to (hc,vc) = (700,2).
    for (int i = 0; i < 10000 && t_def < 2 * (2 * 800 + 700); i++) begin
      step();
      n_cmp++;
      if (obs_d !== exp_d()) begin
        n_bad++;
        if (n_bad < 40) $display("FAIL mid_walk t=%0d got=%h exp=%h", t_def, obs_d, exp_d());
      end
    end
    n_cmp++;
    if (d_x !== 10'd700 || d_y !== 10'd2 || d_hs !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_position got=(%0d,%0d,hs=%b) exp=(700,2,hs=0)", d_x, d_y, d_hs);
    end
    rst_def = 1'b0;
    t_def = 0;
    #1;
    n_cmp++;
    if (obs_d !== exp_d()) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", obs_d, exp_d());
    end
    hold = 1 + int'($urandom_range(0, 4));
    for (int i = 0; i < hold; i++) step();
    rst_def = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      n_cmp++;
      if (obs_d !== exp_d()) begin
        n_bad++;
        if (n_bad < 40) $display("FAIL mid_restart t=%0d got=%h exp=%h", t_def, obs_d, exp_d());
      end
    end
  endtask

  task automatic test_frame();
    int pulses, vs_low;
    pulses = 0; vs_low = 0;
    rst_small = 1'b1;
    for (int i = 0; i < 3 * S_FRAME + 5; i++) begin
      step();
      n_cmp++;
      if (obs_s !== exp_s()) begin
        n_bad++;
        if (n_bad < 40) $display("FAIL frame_vec t=%0d got=%h exp=%h", t_small, obs_s, exp_s());
      end
      if (s_fs) pulses++;
      if (!s_vs) vs_low++;
    end
    n_cmp++;
    if (pulses != 3) begin
      n_bad++;
      $display("FAIL frame_start_count got=%0d exp=3", pulses);
    end
    n_cmp++;
    if (vs_low != 3 * 2 * S_VS * (S_HV + S_HF + S_HS + S_HB)) begin
      n_bad++;
      $display("FAIL vs_low_cycles got=%0d exp=%0d", vs_low,
               3 * 2 * S_VS * (S_HV + S_HF + S_HS + S_HB));
    end
  endtask

  task automatic test_back_to_back();
    int last_fs, last_fr, n_fs, n_fr;
    logic prev_fclk;
    last_fs = -1; last_fr = -1; n_fs = 0; n_fr = 0;
    prev_fclk = s_fclk;
    for (int i = 0; i < 4 * S_FRAME + 10; i++) begin
      step();
      if (s_fs) begin
        if (last_fs >= 0) begin
          n_fs++;
          n_cmp++;
          if (t_small - last_fs != S_FRAME) begin
            n_bad++;
            $display("FAIL frame_start_spacing got=%0d exp=%0d", t_small - last_fs, S_FRAME);
          end
        end
        last_fs = t_small;
      end
      if (!prev_fclk && s_fclk) begin
        if (last_fr >= 0) begin
          n_fr++;
          n_cmp++;
          if (t_small - last_fr != S_FRAME) begin
            n_bad++;
            $display("FAIL frame_clk_spacing got=%0d exp=%0d", t_small - last_fr, S_FRAME);
          end
        end
        last_fr = t_small;
      end
      prev_fclk = s_fclk;
    end
    n_cmp++;
    if (n_fs < 3 || n_fr < 3) begin
      n_bad++;
      $display("FAIL spacing_samples got=%0d/%0d exp>=3/3", n_fs, n_fr);
    end
  endtask

  task automatic test_random_reset();
    int run_len, hold;
    for (int r = 0; r < 3; r++) begin
      run_len = int'($urandom_range(100, S_FRAME - 20));
      for (int i = 0; i < run_len; i++) step();
      rst_small = 1'b0;
      t_small = 0;
      #1;
      n_cmp++;
      if (obs_s !== exp_s()) begin
        n_bad++;
        $display("FAIL rand_async_reset r=%0d got=%h exp=%h", r, obs_s, exp_s());
      end
      hold = 1 + int'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++) step();
      rst_small = 1'b1;
      for (int i = 0; i < S_FRAME + 40; i++) begin
        step();
        n_cmp++;
        if (obs_s !== exp_s()) begin
          n_bad++;
          if (n_bad < 40) $display("FAIL rand_restart t=%0d got=%h exp=%h", t_small, obs_s, exp_s());
        end
      end
    end
  endtask

  task automatic test_div4();
    logic prev_hs;
    logic [9:0] prev_x;
    int run_cnt, changes;
    rst_d4 = 1'b1;
    prev_hs = q_hs; prev_x = q_x; run_cnt = 0; changes = 0;
    for (int i = 0; i < 2 * 3200 + 20; i++) begin
      step();
      n_cmp++;
      if (obs_q !== exp_q()) begin
        n_bad++;
        if (n_bad < 40) $display("FAIL div4_vec t=%0d got=%h exp=%h", t_d4, obs_q, exp_q());
      end
      run_cnt++;
      if (q_x != prev_x) begin
        changes++;
        if (changes > 1 && changes < 20) begin
          n_cmp++;
          if (run_cnt != 4) begin
            n_bad++;
            $display("FAIL div4_pixel_len got=%0d exp=4", run_cnt);
          end
        end
        run_cnt = 0;
      end
      if (prev_hs != q_hs) begin
        n_cmp++;
        if (q_x !== (q_hs ? 10'd752 : 10'd656)) begin
          n_bad++;
          $display("FAIL div4_hs_edge got=%0d exp=%0d", q_x, q_hs ? 752 : 656);
        end
      end
      prev_hs = q_hs; prev_x = q_x;
    end
  endtask

  initial begin
    rst_def = 1'b0;
    rst_small = 1'b0;
    rst_d4 = 1'b0;
    test_reset();
    test_line();
    test_midframe_reset();
    test_frame();
    test_back_to_back();
    test_random_reset();
    test_div4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
